// File: rtl/audio_stream_pkg.sv
// Shared types and default constants for the UART-to-I2S audio stream scheduler.
// The defaults target a 27 MHz clock, 48 kHz playback and a 456000 baud link.
package audio_stream_pkg;

  typedef enum logic [0:0] {
    ST_PREFILL = 1'b0,
    ST_PLAY    = 1'b1
  } state_t;

  localparam int DEFAULT_BYTES_PER_SAMPLE = 3;
  localparam int DEFAULT_FIFO_DEPTH       = 256;
  localparam int DEFAULT_START_LEVEL      = 128;
  // 27 MHz / 48 kHz, and roughly 4.5 byte times of idle line at 456000 baud
  localparam int DEFAULT_SAMPLE_DIV       = 562;
  localparam int DEFAULT_RESYNC_CYCLES    = 2700;

  function automatic int sample_width(input int bytes_per_sample);
    return 8 * bytes_per_sample;
  endfunction

endpackage

// File: rtl/audio_stream_scheduler_sample_fifo.sv
// First-word-fall-through sample FIFO: reset-free storage array plus a head
// register that always holds the oldest entry while the FIFO is non-empty.
module sample_fifo #(
  parameter int  DATA_W  = 24,
  parameter int  DEPTH   = 256,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int COUNT_W = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               rd_en,
  output logic [DATA_W-1:0]  rd_data,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  localparam logic [ADDR_W:0]    PTR_ONE   = (ADDR_W + 1)'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [ADDR_W:0]    wr_ptr_r;
  logic [ADDR_W:0]    rd_ptr_r;
  logic [ADDR_W:0]    rd_ptr_next_s;
  logic [COUNT_W-1:0] count_r;
  logic [DATA_W-1:0]  rd_data_r;
  logic               push_s;
  logic               pop_s;
  logic               head_bypass_s;

  assign empty         = (wr_ptr_r == rd_ptr_r);
  assign full          = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                         (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
  assign pop_s         = rd_en && !empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign push_s        = wr_en && (!full || pop_s);
  assign rd_ptr_next_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
  assign head_bypass_s = push_s && (wr_ptr_r[ADDR_W-1:0] == rd_ptr_next_s[ADDR_W-1:0]);
  assign rd_data       = rd_data_r;
  assign count         = count_r;

  // Storage array, written on every accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Head register: reads the slot that becomes the head, forwarding a same-slot write.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_data_r <= '0;
    end else if (head_bypass_s) begin
      rd_data_r <= wr_data;
    end else begin
      rd_data_r <= mem_r[rd_ptr_next_s[ADDR_W-1:0]];
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/audio_stream_scheduler.sv
// Packs UART bytes into little-endian PCM samples, buffers them, and releases
// one sample per divider period so playback is paced by the system clock.
module audio_stream_scheduler
  import audio_stream_pkg::*;
#(
  parameter int  BYTES_PER_SAMPLE = DEFAULT_BYTES_PER_SAMPLE,
  parameter int  SAMPLE_DIV       = DEFAULT_SAMPLE_DIV,
  parameter int  FIFO_DEPTH       = DEFAULT_FIFO_DEPTH,
  parameter int  START_LEVEL      = DEFAULT_START_LEVEL,
  parameter int  RESYNC_CYCLES    = DEFAULT_RESYNC_CYCLES,
  localparam int SAMPLE_W         = sample_width(BYTES_PER_SAMPLE),
  localparam int LEVEL_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  input  logic                flush,
  input  logic                clr_flags,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                playing,
  output logic [LEVEL_W-1:0]  fill_level,
  output logic                overrun,
  output logic [15:0]         underrun_cnt
);

  localparam int IDX_W  = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int GAP_W  = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
  localparam int PART_W = SAMPLE_W - 8;

  localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(BYTES_PER_SAMPLE - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE      = IDX_W'(1);
  localparam logic [DIV_W-1:0]   DIV_LAST     = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE      = DIV_W'(1);
  localparam logic [GAP_W-1:0]   GAP_LAST     = GAP_W'(RESYNC_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_ONE      = GAP_W'(1);
  localparam logic [LEVEL_W-1:0] START_LVL    = LEVEL_W'(START_LEVEL);
  localparam logic [15:0]        UNDERRUN_MAX = 16'hFFFF;

  state_t              state_r;
  logic [IDX_W-1:0]    idx_r;
  logic [GAP_W-1:0]    gap_r;
  logic [PART_W-1:0]   partial_r;
  logic [DIV_W-1:0]    div_r;

  logic                tick_s;
  logic                push_s;
  logic                pop_s;
  logic                drop_s;
  logic                underrun_s;
  logic [SAMPLE_W-1:0] wr_data_s;
  logic [SAMPLE_W-1:0] fifo_rd_data_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;

  assign tick_s     = (div_r == DIV_LAST);
  assign push_s     = byte_valid && (idx_r == LAST_IDX) && !flush;
  assign pop_s      = (state_r == ST_PLAY) && tick_s && !fifo_empty_s && !flush;
  assign underrun_s = (state_r == ST_PLAY) && tick_s && fifo_empty_s && !flush;
  assign drop_s     = push_s && fifo_full_s && !pop_s;
  assign wr_data_s  = {byte_in, partial_r};
  assign playing    = (state_r == ST_PLAY);

  sample_fifo #(
    .DATA_W (SAMPLE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_sample_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .wr_en   (push_s),
    .wr_data (wr_data_s),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_data_s),
    .count   (fill_level),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Byte assembler; an idle line mid-sample drops the partial sample to realign.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      idx_r     <= '0;
      gap_r     <= '0;
      partial_r <= '0;
    end else if (byte_valid) begin
      gap_r <= '0;
      if (idx_r == LAST_IDX) begin
        idx_r <= '0;
      end else begin
        partial_r[{idx_r, 3'b000} +: 8] <= byte_in;
        idx_r                           <= idx_r + IDX_ONE;
      end
    end else if (idx_r != '0) begin
      if (gap_r == GAP_LAST) begin
        idx_r <= '0;
        gap_r <= '0;
      end else begin
        gap_r <= gap_r + GAP_ONE;
      end
    end else begin
      gap_r <= '0;
    end
  end

  // Free-running sample-period divider.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Playback FSM with registered sample outputs and sticky status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_PREFILL;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      underrun_cnt <= '0;
    end else if (flush) begin
      state_r      <= ST_PREFILL;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick_s;
      if (drop_s) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end
      if (clr_flags) begin
        underrun_cnt <= '0;
      end else if (underrun_s && (underrun_cnt != UNDERRUN_MAX)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
      case (state_r)
        ST_PREFILL: begin
          // Silence keeps the DAC clocked while the buffer fills.
          if (tick_s) begin
            sample_out <= '0;
          end
          if (fill_level >= START_LVL) begin
            state_r <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick_s) begin
            if (!fifo_empty_s) begin
              sample_out <= fifo_rd_data_s;
            end else begin
              sample_out <= '0;
              state_r    <= ST_PREFILL;
            end
          end
        end
        default: begin
          state_r <= ST_PREFILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_stream_scheduler.sv
// Directed bench for audio_stream_scheduler with a short divider and tiny FIFO;
// phase counts clock edges since the last reset/flush edge.
module tb_audio_stream_scheduler;

  localparam logic [23:0] SBASE = 24'hC0FFE1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        flush;
  logic        clr_flags;
  logic [23:0] sample_out;
  logic        sample_valid;
  logic        playing;
  logic [2:0]  fill_level;
  logic        overrun;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int errors = 0;
  int phase  = 0;

  always #5 clk = ~clk;

  audio_stream_scheduler #(
    .BYTES_PER_SAMPLE (3),
    .SAMPLE_DIV       (8),
    .FIFO_DEPTH       (4),
    .START_LEVEL      (2),
    .RESYNC_CYCLES    (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .flush        (flush),
    .clr_flags    (clr_flags),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .playing      (playing),
    .fill_level   (fill_level),
    .overrun      (overrun),
    .underrun_cnt (underrun_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
    phase++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    cyc();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic send_sample(input logic [23:0] v);
    send_byte(v[7:0]);
    send_byte(v[15:8]);
    send_byte(v[23:16]);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    phase = 0;
  endtask

  task automatic run_to(input int p);
    while (phase < p) cyc();
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (sample_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_playing(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (playing === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; flush = 1'b0; clr_flags = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    phase = 0;
    checks++;
    if ({sample_out, sample_valid, playing, fill_level, overrun, underrun_cnt} !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%h v=%b p=%b fill=%0d ovr=%b und=%0d, expected all 0",
               sample_out, sample_valid, playing, fill_level, overrun, underrun_cnt);
    end
  endtask

  task automatic test_idle();
    bit exp_v;
    int pulses = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      exp_v = (phase % 8 == 0);
      if (sample_valid === 1'b1) pulses++;
      checks++;
      if (sample_valid !== exp_v) begin
        errors++;
        $display("FAIL idle_valid phase %0d: got %b expected %b", phase, sample_valid, exp_v);
      end
      checks++;
      if ({sample_out, playing, fill_level, overrun, underrun_cnt} !== 46'd0) begin
        errors++;
        $display("FAIL idle_state phase %0d: got out=%h p=%b fill=%0d ovr=%b und=%0d, expected all 0",
                 phase, sample_out, playing, fill_level, overrun, underrun_cnt);
      end
    end
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("FAIL idle_pulse_count: got %0d expected 5", pulses);
    end
  endtask

  task automatic expect_pulse(input string name, input logic [23:0] exp_out, input logic exp_play,
                              input logic [15:0] exp_und);
    bit ok;
    wait_pulse(ok);
    checks++;
    if (!ok || sample_out !== exp_out || playing !== exp_play || underrun_cnt !== exp_und) begin
      errors++;
      $display("FAIL %s: got seen=%b out=%h p=%b und=%0d expected seen=1 out=%h p=%b und=%0d",
               name, ok, sample_out, playing, underrun_cnt, exp_out, exp_play, exp_und);
    end
  endtask

  task automatic test_playback();
    bit ok;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    checks++;
    if (fill_level !== 3'd1) begin
      errors++; $display("FAIL play_fill1: got %0d expected 1", fill_level);
    end
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    checks++;
    if (fill_level !== 3'd2) begin
      errors++; $display("FAIL play_fill2: got %0d expected 2", fill_level);
    end
    wait_playing(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL play_start: got playing=%b expected 1", playing);
    end
    expect_pulse("play_first", 24'h332211, 1'b1, 16'd0);
    expect_pulse("play_second", 24'h665544, 1'b1, 16'd0);
    expect_pulse("play_underrun", 24'h000000, 1'b0, 16'd1);
  endtask

  task automatic test_resync();
    bit ok;
    send_byte(8'hAA); send_byte(8'hBB);
    for (int i = 0; i < 25; i++) cyc();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    checks++;
    if (fill_level !== 3'd1) begin
      errors++; $display("FAIL resync_fill: got %0d expected 1", fill_level);
    end
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    wait_playing(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL resync_start: got playing=%b expected 1", playing);
    end
    expect_pulse("resync_first", 24'h030201, 1'b1, 16'd1);
    expect_pulse("resync_second", 24'h060504, 1'b1, 16'd1);
    expect_pulse("resync_underrun", 24'h000000, 1'b0, 16'd2);
  endtask

  task automatic test_overrun();
    logic [23:0] s;
    do_flush();
    checks++;
    if (underrun_cnt !== 16'd2 || fill_level !== 3'd0 || playing !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL flush_keeps_underrun: got und=%0d fill=%0d p=%b ovr=%b expected und=2 fill=0 p=0 ovr=0",
               underrun_cnt, fill_level, playing, overrun);
    end
    for (int n = 0; n < 21; n++) begin
      s = SBASE + 24'(n / 3);
      send_byte(s[8*(n%3) +: 8]);
      if (phase == 8 || phase == 16) begin
        s = SBASE + 24'(phase / 8 - 1);
        checks++;
        if (sample_valid !== 1'b1 || sample_out !== s) begin
          errors++;
          $display("FAIL overrun_pop phase %0d: got v=%b out=%h expected v=1 out=%h",
                   phase, sample_valid, sample_out, s);
        end
      end
    end
    checks++;
    if (fill_level !== 3'd4 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_full: got fill=%0d ovr=%b expected fill=4 ovr=1", fill_level, overrun);
    end
  endtask

  task automatic test_clear_and_full_push();
    logic [23:0] s;
    s = SBASE + 24'd7;
    clr_flags = 1'b1;
    send_byte(s[7:0]);
    clr_flags = 1'b0;
    checks++;
    if (overrun !== 1'b0 || underrun_cnt !== 16'd0 || fill_level !== 3'd4) begin
      errors++;
      $display("FAIL clr_flags: got ovr=%b und=%0d fill=%0d expected ovr=0 und=0 fill=4",
               overrun, underrun_cnt, fill_level);
    end
    send_byte(s[15:8]);
    send_byte(s[23:16]);
    checks++;
    if (fill_level !== 3'd4 || overrun !== 1'b0 || sample_valid !== 1'b1 || sample_out !== SBASE + 24'd2) begin
      errors++;
      $display("FAIL full_push_pop: got fill=%0d ovr=%b v=%b out=%h expected fill=4 ovr=0 v=1 out=%h",
               fill_level, overrun, sample_valid, sample_out, SBASE + 24'd2);
    end
  endtask

  task automatic test_flush();
    send_sample(SBASE + 24'd8);
    checks++;
    if (overrun !== 1'b1 || fill_level !== 3'd4) begin
      errors++; $display("FAIL drop_again: got ovr=%b fill=%0d expected ovr=1 fill=4", overrun, fill_level);
    end
    run_to(32);
    checks++;
    if (fill_level !== 3'd3 || sample_out !== SBASE + 24'd3) begin
      errors++;
      $display("FAIL pre_flush: got fill=%0d out=%h expected fill=3 out=%h", fill_level, sample_out, SBASE + 24'd3);
    end
    send_byte(8'h5A);
    do_flush();
    checks++;
    if (sample_out !== 24'd0 || sample_valid !== 1'b0 || playing !== 1'b0 || fill_level !== 3'd0) begin
      errors++;
      $display("FAIL flush_clear: got out=%h v=%b p=%b fill=%0d expected all 0",
               sample_out, sample_valid, playing, fill_level);
    end
    checks++;
    if (overrun !== 1'b1 || underrun_cnt !== 16'd0) begin
      errors++; $display("FAIL flush_keep_flags: got ovr=%b und=%0d expected ovr=1 und=0", overrun, underrun_cnt);
    end
    send_byte(8'h01); send_byte(8'h02);
    checks++;
    if (fill_level !== 3'd0) begin
      errors++; $display("FAIL flush_idx_partial: got fill=%0d expected 0", fill_level);
    end
    send_byte(8'h03);
    checks++;
    if (fill_level !== 3'd1) begin
      errors++; $display("FAIL flush_idx_full: got fill=%0d expected 1", fill_level);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) send_sample(24'h100000 + 24'(i));
    run_to(16);
    checks++;
    if (fill_level !== 3'd3 || playing !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got fill=%0d p=%b ovr=%b expected fill=3 p=1 ovr=1", fill_level, playing, overrun);
    end
    send_byte(8'hA5);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    phase = 0;
    checks++;
    if ({sample_out, sample_valid, playing, fill_level, overrun, underrun_cnt} !== 47'd0) begin
      errors++;
      $display("FAIL midstream_reset: got out=%h v=%b p=%b fill=%0d ovr=%b und=%0d, expected all 0",
               sample_out, sample_valid, playing, fill_level, overrun, underrun_cnt);
    end
    send_byte(8'h07); send_byte(8'h08);
    checks++;
    if (fill_level !== 3'd0) begin
      errors++; $display("FAIL reset_idx_partial: got fill=%0d expected 0", fill_level);
    end
    send_byte(8'h09);
    checks++;
    if (fill_level !== 3'd1) begin
      errors++; $display("FAIL reset_idx_full: got fill=%0d expected 1", fill_level);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_playback();
    test_resync();
    test_overrun();
    test_clear_and_full_push();
    test_flush();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
